diffeq_loader: RTL and testbench
================================

Name: diffeq_loader

Overview:
- Operand-side initiator for the differential-equation solver's controller.
- Snapshots four operands (x, dx, a, u) on a start pulse, then presents them one at a time on a shared data bus with one-hot select strobes s1..s4.
- Raises ready and waits for the controller's valid, then captures the result.
- Sits between the host/testbench and the controller + datapath, driving the controller's s1..s4/ready inputs and consuming its valid output.

Parameters:
- WIDTH, 16: operand/result bit width.
- HOLD_CYCLES, 1: cycles each select strobe stays high (>=1).
- TIMEOUT_CYCLES, 1024: max cycles in WAIT without a valid rising edge; 0 disables the timeout.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- x_in, dx_in, a_in, u_in  in  WIDTH each  operands, sampled when start is accepted.
- y_in  in  WIDTH  solver result, sampled on a valid rising edge.
- valid_in  in  1  controller's valid (level; stays high while the controller is done).
- s1, s2, s3, s4  out  1 each  one-hot select strobes: x, dx, a, u.
- data_out  out  WIDTH  operand matching the active strobe.
- ready  out  1  all operands presented; solver may run.
- busy  out  1  high in every state except IDLE.
- result_out  out  WIDTH  last captured result.
- done  out  1  one-cycle pulse on result capture.
- err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (async, reset=0): FSM to IDLE; every output 0, including result_out and data_out; operand regs, counters and valid_d cleared. Applies at any point mid-operation; the sequence restarts only on a new start.
- States: IDLE, DRIVE, GAP, WAIT.
  - IDLE -> DRIVE when start=1. Operands latch into internal regs at that edge; later input changes are ignored.
  - DRIVE(idx 0..3): exactly one strobe s[idx+1]=1; data_out = operand[idx] (idx0=x, 1=dx, 2=a, 3=u). Held HOLD_CYCLES cycles, then -> GAP.
  - GAP: all strobes 0; data_out holds the last value for 1 cycle. If idx<3: idx+1, -> DRIVE. Else -> WAIT.
  - WAIT: ready=1, all strobes 0, timeout counter runs.
    - valid rising edge (valid_in=1 and valid_d=0): result_out <= y_in, done=1 next cycle, ready=0, -> IDLE.
    - Counter reaches TIMEOUT_CYCLES: err=1 next cycle, ready=0, -> IDLE; result_out unchanged.
- Timing (HOLD_CYCLES=1, start sampled at edge 0, "cycle n" = after edge n):
  - s1 in cycle 1, s2 in cycle 3, s3 in cycle 5, s4 in cycle 7.
  - ready from cycle 9.
  - General: ready at cycle 4*(HOLD_CYCLES+1)+1.
- Strobes are never simultaneously high; at most one is high in any cycle.
- valid_d is a registered copy of valid_in, updated every cycle in all states. A level-high valid held over from a previous run never triggers capture.
- valid_in, y_in: ignored outside WAIT.
- start: ignored outside IDLE.
- Valid rising edge and timeout expiry in the same cycle: capture wins; done=1, err=0.
- done/err pulse in the first IDLE cycle (busy=0). A start in that cycle is accepted.
- Timeout counter is clog2(TIMEOUT_CYCLES+1) bits; cleared on WAIT entry; saturates, never wraps.

Test Plan:
- Basic load, HOLD_CYCLES=1: start with x=3, dx=1, a=10, u=2 -> s1/data=3 @c1, s2/data=1 @c3, s3/data=10 @c5, s4/data=2 @c7, ready=1 @c9, busy=1 c1..c9+.
- Capture: in WAIT, drive y_in=0x00AB, valid_in 0->1 -> result_out=0x00AB, done=1 for exactly 1 cycle, ready=0, busy=0. Holding valid_in high afterwards produces no second done.
- Stale valid: valid_in held high from the previous run; new start with x=5 -> full strobe sequence, no capture until valid_in drops and rises again.
- Timeout, TIMEOUT_CYCLES=8: no valid edge -> err pulses 9 cycles after ready rises, ready=0, result_out unchanged.
- Same-cycle priority: valid rising edge on the exact expiry cycle -> done=1, err=0.
- Reset mid-run: reset=0 while s3 is high -> all outputs 0 immediately (async). Release, start with x=7 -> sequence restarts at s1 with data=7. A start pulse during busy (e.g. at c4) has no effect.

Source files
------------

// File: rtl/diffeq_loader.sv
// Purpose: snapshots x/dx/a/u on start, presents them one-hot-strobed on a shared bus, then waits for the solver result.
// Latency: s1 one cycle after start; ready at 4*(HOLD_CYCLES+1)+1 cycles; done/err one cycle after capture/expiry.
// Backpressure: start is ignored while busy; the WAIT state holds ready until a valid rising edge or the timeout expires.
module diffeq_loader #(
  parameter int WIDTH          = 16,
  parameter int HOLD_CYCLES    = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_x_in,
  input  logic [WIDTH-1:0] i_dx_in,
  input  logic [WIDTH-1:0] i_a_in,
  input  logic [WIDTH-1:0] i_u_in,
  input  logic [WIDTH-1:0] i_y_in,
  input  logic             i_valid_in,
  output logic             o_s1,
  output logic             o_s2,
  output logic             o_s3,
  output logic             o_s4,
  output logic [WIDTH-1:0] o_data_out,
  output logic             o_ready,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_result_out,
  output logic             o_done,
  output logic             o_err
);

  // A zero timeout disables expiry, but the counter still needs at least one bit.
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  state_t           r_state;
  logic [1:0]       r_idx;
  logic [HW-1:0]    r_hold_cnt;
  logic [TW-1:0]    r_to_cnt;
  logic             r_valid_d;
  logic [WIDTH-1:0] r_op [4];
  logic [3:0]       r_sel;
  logic [WIDTH-1:0] r_data;
  logic             r_ready;
  logic [WIDTH-1:0] r_result;
  logic             r_done;
  logic             r_err;

  logic [1:0]       w_idx_nxt;
  logic             w_valid_rise;
  logic             w_expired;

  assign w_idx_nxt    = r_idx + 2'd1;
  // A valid level left over from an earlier run has no edge, so it cannot capture.
  assign w_valid_rise = i_valid_in & ~r_valid_d;
  assign w_expired    = (TIMEOUT_CYCLES != 0) && (r_to_cnt == TW'(TIMEOUT_CYCLES));

  assign o_s1         = r_sel[0];
  assign o_s2         = r_sel[1];
  assign o_s3         = r_sel[2];
  assign o_s4         = r_sel[3];
  assign o_data_out   = r_data;
  assign o_ready      = r_ready;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_result_out = r_result;
  assign o_done       = r_done;
  assign o_err        = r_err;

  // Track the previous valid level in every state for rising-edge detection.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_valid_d <= 1'b0;
    else          r_valid_d <= i_valid_in;
  end

  // Sequencer: snapshot operands, strobe each for HOLD_CYCLES with a one-cycle gap, then wait for the result.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= 2'd0;
      r_hold_cnt <= '0;
      r_to_cnt   <= '0;
      for (int i = 0; i < 4; i++) r_op[i] <= '0;
      r_sel      <= 4'b0000;
      r_data     <= '0;
      r_ready    <= 1'b0;
      r_result   <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_op[0]    <= i_x_in;
            r_op[1]    <= i_dx_in;
            r_op[2]    <= i_a_in;
            r_op[3]    <= i_u_in;
            r_idx      <= 2'd0;
            r_hold_cnt <= '0;
            r_sel      <= 4'b0001;
            r_data     <= i_x_in;
            r_state    <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (r_hold_cnt == HW'(HOLD_CYCLES - 1)) begin
            r_sel   <= 4'b0000;
            r_state <= ST_GAP;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          // data_out keeps the last operand through the gap.
          if (r_idx != 2'd3) begin
            r_idx      <= w_idx_nxt;
            r_hold_cnt <= '0;
            r_sel      <= 4'b0001 << w_idx_nxt;
            r_data     <= r_op[w_idx_nxt];
            r_state    <= ST_DRIVE;
          end else begin
            r_ready  <= 1'b1;
            r_to_cnt <= '0;
            r_state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Capture has priority over an expiry landing on the same edge.
          if (w_valid_rise) begin
            r_result <= i_y_in;
            r_done   <= 1'b1;
            r_ready  <= 1'b0;
            r_state  <= ST_IDLE;
          end else if (w_expired) begin
            r_err   <= 1'b1;
            r_ready <= 1'b0;
            r_state <= ST_IDLE;
          end else if (r_to_cnt != '1) begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_diffeq_loader.sv
// Bench for diffeq_loader: directed and random load/capture/timeout sequences against a cycle-arithmetic reference.
// Inputs driven and outputs sampled on the falling edge; DUT state changes on the rising edge.
// Timeout shortened to 8 cycles so expiry and same-cycle priority are reachable quickly.
module tb_diffeq_loader;
  localparam int W       = 16;
  localparam int H       = 1;
  localparam int TO      = 8;
  localparam int LOADLEN = 4 * (H + 1) + 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] x_in, dx_in, a_in, u_in, y_in;
  logic         valid_in;
  logic         s1, s2, s3, s4, ready, busy, done, err;
  logic [W-1:0] data_out, result_out;

  int           n_checks = 0;
  int           n_err    = 0;
  logic [W-1:0] exp_result = '0;
  int           wait_k = 0;

  always #5 clk = ~clk;

  diffeq_loader #(.WIDTH(W), .HOLD_CYCLES(H), .TIMEOUT_CYCLES(TO)) u_dut (
    .i_clk(clk), .i_reset(rst_n), .i_start(start),
    .i_x_in(x_in), .i_dx_in(dx_in), .i_a_in(a_in), .i_u_in(u_in),
    .i_y_in(y_in), .i_valid_in(valid_in),
    .o_s1(s1), .o_s2(s2), .o_s3(s3), .o_s4(s4),
    .o_data_out(data_out), .o_ready(ready), .o_busy(busy),
    .o_result_out(result_out), .o_done(done), .o_err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_strobes"}, {28'd0, s4, s3, s2, s1}, 32'd0);
    chk({tag, "_data"},    {16'd0, data_out}, 32'd0);
    chk({tag, "_ready"},   {31'd0, ready}, 32'd0);
    chk({tag, "_busy"},    {31'd0, busy}, 32'd0);
    chk({tag, "_result"},  {16'd0, result_out}, 32'd0);
    chk({tag, "_done"},    {31'd0, done}, 32'd0);
    chk({tag, "_err"},     {31'd0, err}, 32'd0);
  endtask

  // Start a load at the current falling edge and check every cycle up to the first ready cycle.
  // abort_at > 0 asserts reset asynchronously in that cycle and returns after releasing it.
  task automatic load(input logic [W-1:0] ox, input logic [W-1:0] odx,
                      input logic [W-1:0] oa, input logic [W-1:0] ou,
                      input bit mid_pulse, input int abort_at);
    logic [W-1:0] ops [4];
    int           slot;
    int           ph;
    logic [3:0]   es;
    ops   = '{ox, odx, oa, ou};
    x_in  = ox; dx_in = odx; a_in = oa; u_in = ou;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x_in  = W'($urandom); dx_in = W'($urandom); a_in = W'($urandom); u_in = W'($urandom);
    for (int n = 1; n <= LOADLEN; n++) begin
      slot = (n - 1) / (H + 1);
      ph   = (n - 1) % (H + 1);
      es   = (slot < 4 && ph < H) ? 4'(1 << slot) : 4'd0;
      chk($sformatf("strobe_c%0d", n), {28'd0, s4, s3, s2, s1}, {28'd0, es});
      if (slot < 4) chk($sformatf("data_c%0d", n), {16'd0, data_out}, {16'd0, ops[slot]});
      chk($sformatf("ready_c%0d", n), {31'd0, ready}, (n == LOADLEN) ? 32'd1 : 32'd0);
      chk($sformatf("busy_c%0d", n), {31'd0, busy}, 32'd1);
      chk($sformatf("done_c%0d", n), {30'd0, done, err}, 32'd0);
      if (n == abort_at) begin
        #1 rst_n = 1'b0;
        #1 check_idle_zero("async_rst");
        valid_in   = 1'b0;
        exp_result = '0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      start = mid_pulse && (n == 3);
      if (n < LOADLEN) @(negedge clk);
    end
    start  = 1'b0;
    wait_k = 0;
  endtask

  // One WAIT-state cycle: drive valid/y, then check the outcome the rules predict for that edge.
  task automatic wait_step(input logic v, input logic [W-1:0] yv, output bit ended);
    bit rise;
    rise     = v && !valid_in;
    valid_in = v;
    y_in     = yv;
    @(negedge clk);
    if (rise) begin
      exp_result = yv;
      chk("cap_done", {31'd0, done}, 32'd1);
      chk("cap_err", {31'd0, err}, 32'd0);
      chk("cap_ready", {31'd0, ready}, 32'd0);
      chk("cap_busy", {31'd0, busy}, 32'd0);
      ended = 1'b1;
    end else if (wait_k == TO) begin
      chk("to_err", {31'd0, err}, 32'd1);
      chk("to_done", {31'd0, done}, 32'd0);
      chk("to_ready", {31'd0, ready}, 32'd0);
      chk("to_busy", {31'd0, busy}, 32'd0);
      ended = 1'b1;
    end else begin
      chk($sformatf("wait_k%0d", wait_k), {29'd0, ready, busy, done, err}, 32'b1100);
      ended = 1'b0;
      wait_k++;
    end
    chk("result", {16'd0, result_out}, {16'd0, exp_result});
  endtask

  // Keep valid low for 'delay' WAIT cycles, then high; bounded so a stuck DUT still reaches the summary.
  task automatic run_wait(input int delay);
    bit ended;
    ended = 1'b0;
    for (int s = 0; s <= TO + 1 && !ended; s++)
      wait_step((s >= delay) ? 1'b1 : 1'b0, W'($urandom), ended);
    chk("wait_bound", {31'd0, ended}, 32'd1);
  endtask

  initial begin
    bit e;
    rst_n = 1'b0; start = 1'b0; valid_in = 1'b0;
    x_in = '0; dx_in = '0; a_in = '0; u_in = '0; y_in = '0;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic load and capture; valid held high afterwards must not capture again.
    load(16'd3, 16'd1, 16'd10, 16'd2, 1'b0, 0);
    wait_step(1'b1, 16'h00AB, e);
    chk("basic_cap", {31'd0, e}, 32'd1);
    chk("basic_result", {16'd0, result_out}, 32'h00AB);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("held_valid_done", {31'd0, done}, 32'd0);
      chk("held_valid_busy", {31'd0, busy}, 32'd0);
    end

    // Stale valid level: no capture until valid falls and rises again.
    load(16'd5, W'($urandom), W'($urandom), W'($urandom), 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      wait_step(1'b1, W'($urandom), e);
      chk("stale_no_cap", {31'd0, e}, 32'd0);
    end
    wait_step(1'b0, W'($urandom), e);
    wait_step(1'b1, 16'h1234, e);
    chk("stale_cap", {31'd0, e}, 32'd1);

    // Timeout: valid never rises, err 9 cycles after ready.
    load(W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'b0, 0);
    run_wait(99);
    @(negedge clk);
    chk("err_pulse_end", {31'd0, err}, 32'd0);

    // Valid rising on the expiry edge: capture wins.
    load(W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'b0, 0);
    run_wait(TO);

    // Random transactions, back-to-back from the done/err cycle.
    for (int t = 0; t < 8; t++) begin
      valid_in = 1'($urandom);
      load(W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'b0, 0);
      run_wait(int'($urandom_range(0, TO + 3)));
    end

    // Reset while s3 is high, then a fresh run with a start pulse ignored mid-sequence.
    @(negedge clk);
    load(W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'b0, 5);
    check_idle_zero("post_rst");
    load(16'd7, W'($urandom), W'($urandom), W'($urandom), 1'b1, 0);
    run_wait(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
